// File: rtl/qfilt_buf.sv
`default_nettype none
// ============================================================================
// Module   : qfilt_buf
// Brief    : Tagged-union stream filter with a small committed-entry output
//            FIFO. Items whose tag is enabled in SEL_MASK are passed; eot bits
//            of dropped items are OR-merged into the last passed item.
// Revision : 1.0 - initial release
// ============================================================================
module qfilt_buf #(
  parameter int                      W_DIN      = 16,
  parameter int                      W_DOUT     = 16,
  parameter int                      W_CTRL     = 1,
  parameter int                      LVL        = 1,
  parameter logic [(1<<W_CTRL)-1:0]  SEL_MASK   = 'b01,
  parameter int                      DEPTH      = 2,
  parameter bit                      DROP_EMPTY = 1'b1
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          din_valid,
  output logic                          din_ready,
  input  logic [W_DIN+W_CTRL+LVL-1:0]   din_data,
  output logic                          dout_valid,
  input  logic                          dout_ready,
  output logic [W_DOUT+LVL-1:0]         dout_data
);

  localparam int c_w_ent = W_DOUT + LVL;
  localparam int c_w_ptr = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int c_w_cnt = $clog2(DEPTH + 1);
  localparam logic [c_w_cnt-1:0] c_depth   = c_w_cnt'(DEPTH);
  localparam logic [c_w_cnt-1:0] c_cnt_one = c_w_cnt'(1);
  localparam logic [c_w_ptr-1:0] c_last    = c_w_ptr'(DEPTH - 1);
  localparam logic [c_w_ptr-1:0] c_ptr_one = c_w_ptr'(1);

  // Input field split: {eot, ctrl, data}
  logic [LVL-1:0]    w_din_eot;
  logic [W_CTRL-1:0] w_din_ctrl;
  logic [W_DOUT-1:0] w_din_dat;
  logic              w_din_unused;

  assign w_din_eot    = din_data[W_DIN+W_CTRL+LVL-1 -: LVL];
  assign w_din_ctrl   = din_data[W_DIN+W_CTRL-1 -: W_CTRL];
  assign w_din_dat    = din_data[W_DOUT-1:0];
  // Upper data bits beyond W_DOUT are intentionally discarded
  assign w_din_unused = ^din_data;

  // Pending item register P
  logic              p_valid_q, p_valid_d;
  logic [LVL-1:0]    p_eot_q, p_eot_d;
  logic [W_DOUT-1:0] p_data_q, p_data_d;

  // Committed-entry FIFO F
  logic [c_w_ent-1:0] mem_q [DEPTH];
  logic [c_w_ent-1:0] mem_d [DEPTH];
  logic [c_w_ptr-1:0] wr_ptr_q, wr_ptr_d;
  logic [c_w_ptr-1:0] rd_ptr_q, rd_ptr_d;
  logic [c_w_cnt-1:0] cnt_q, cnt_d;

  logic               w_sel, w_din_full, w_p_full, w_pop, w_space;
  logic               w_need_push, w_push, w_accept;
  logic [c_w_ent-1:0] w_push_ent;

  assign w_sel      = SEL_MASK[w_din_ctrl];
  assign w_din_full = &w_din_eot;
  assign w_p_full   = p_valid_q && (&p_eot_q);
  assign dout_valid = (cnt_q != '0);
  assign w_pop      = dout_valid && dout_ready;
  // A push is possible when F has a free slot or its head leaves this edge
  assign w_space    = (cnt_q < c_depth) || w_pop;
  assign dout_data  = dout_valid ? mem_q[rd_ptr_q] : '0;

  // Filter decision: what (if anything) is pushed and how P evolves
  always_comb begin
    p_valid_d   = p_valid_q;
    p_eot_d     = p_eot_q;
    p_data_d    = p_data_q;
    w_need_push = 1'b0;
    w_push      = 1'b0;
    w_accept    = 1'b0;
    w_push_ent  = '0;
    din_ready   = 1'b1;
    if (w_p_full) begin
      // A closed item waits in P; it must be committed before anything else
      din_ready = 1'b0;
      if (w_space) begin
        w_push     = 1'b1;
        w_push_ent = {p_eot_q, p_data_q};
        p_valid_d  = 1'b0;
      end
    end else begin
      // Classification uses only din_data so ready is independent of valid
      if (w_sel) begin
        if (p_valid_q) begin
          w_need_push = 1'b1;
          w_push_ent  = {p_eot_q, p_data_q};
        end else if (w_din_full) begin
          w_need_push = 1'b1;
          w_push_ent  = {w_din_eot, w_din_dat};
        end
      end else if (p_valid_q) begin
        if (w_din_full) begin
          w_need_push = 1'b1;
          w_push_ent  = {p_eot_q | w_din_eot, p_data_q};
        end
      end else if (w_din_full && !DROP_EMPTY) begin
        w_need_push = 1'b1;
        w_push_ent  = {w_din_eot, {W_DOUT{1'b0}}};
      end
      din_ready = !w_need_push || w_space;
      w_accept  = din_valid && din_ready;
      w_push    = w_accept && w_need_push;
      if (w_accept) begin
        if (w_sel) begin
          // A closing selected item goes straight to F only when P is empty
          if (p_valid_q || !w_din_full) begin
            p_valid_d = 1'b1;
            p_eot_d   = w_din_eot;
            p_data_d  = w_din_dat;
          end
        end else if (p_valid_q) begin
          p_eot_d = p_eot_q | w_din_eot;
          if (w_din_full) begin
            p_valid_d = 1'b0;
          end
        end
      end
    end
  end

  // FIFO write/read pointers, occupancy and storage update
  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    cnt_d    = cnt_q;
    if (w_push) begin
      mem_d[wr_ptr_q] = w_push_ent;
      wr_ptr_d = (wr_ptr_q == c_last) ? '0 : wr_ptr_q + c_ptr_one;
    end
    if (w_pop) begin
      rd_ptr_d = (rd_ptr_q == c_last) ? '0 : rd_ptr_q + c_ptr_one;
    end
    case ({w_push, w_pop})
      2'b10:   cnt_d = cnt_q + c_cnt_one;
      2'b01:   cnt_d = cnt_q - c_cnt_one;
      default: cnt_d = cnt_q;
    endcase
  end

  // Control state registers with synchronous reset
  always_ff @(posedge clk) begin
    if (rst) begin
      p_valid_q <= 1'b0;
      p_eot_q   <= '0;
      p_data_q  <= '0;
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      cnt_q     <= '0;
    end else begin
      p_valid_q <= p_valid_d;
      p_eot_q   <= p_eot_d;
      p_data_q  <= p_data_d;
      wr_ptr_q  <= wr_ptr_d;
      rd_ptr_q  <= rd_ptr_d;
      cnt_q     <= cnt_d;
    end
  end

  // FIFO storage; contents are qualified by cnt so no reset is needed
  always_ff @(posedge clk) begin
    mem_q <= mem_d;
  end

endmodule
`default_nettype wire
